// File: rtl/sha_round_seq.sv
// SHA-256 round sequencer: walks the round index 0..ROUNDS-1 under a per-round
// advance enable, flags the schedule phase and final round, and counts blocks.
module sha_round_seq #(
  parameter int CNT_W       = 6,
  parameter int ROUNDS      = 64,
  parameter int SCHED_WORDS = 16,
  parameter int BLK_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             cnt_en,
  input  logic             abort,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             sched_sel,
  output logic             last,
  output logic             done,
  output logic [BLK_W-1:0] blk_cnt,
  output logic             state_dbg
);

  // Handshake: start is a request sampled only in IDLE or together with the
  // final advance; busy acknowledges it one cycle later and stays high through
  // RUN; done is a single-cycle completion pulse; abort overrides everything.

  if (ROUNDS < 2 || ROUNDS > (1 << CNT_W)) begin : g_bad_rounds
    $error("sha_round_seq: ROUNDS must satisfy 2 <= ROUNDS <= 2**CNT_W");
  end
  if (SCHED_WORDS < 1 || SCHED_WORDS > ROUNDS) begin : g_bad_sched
    $error("sha_round_seq: SCHED_WORDS must satisfy 1 <= SCHED_WORDS <= ROUNDS");
  end

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(ROUNDS - 1);
  // One extra bit so SCHED_WORDS == 2**CNT_W is representable.
  localparam logic [CNT_W:0]   SCHED_LIM = (CNT_W + 1)'(SCHED_WORDS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [BLK_W-1:0] blk_q, blk_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    blk_d   = blk_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (start) state_d = RUN;
        end
        RUN: begin
          if (cnt_en) begin
            if (cnt_q == LAST_IDX) begin
              // Final advance; a concurrent start chains the next block.
              done_d  = 1'b1;
              blk_d   = blk_q + BLK_W'(1);
              cnt_d   = '0;
              state_d = start ? RUN : IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign cnt       = cnt_q;
  assign busy      = (state_q == RUN);
  assign sched_sel = busy && ({1'b0, cnt_q} < SCHED_LIM);
  assign last      = busy && (cnt_q == LAST_IDX);
  assign done      = done_q;
  assign blk_cnt   = blk_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sha_round_seq.sv
// Directed bench for sha_round_seq: default 64-round instance plus a
// 16-round / 2-bit block counter instance to exercise natural wrap.
module tb_sha_round_seq;

  logic       clk;
  logic       reset_n;
  logic       start, cnt_en, abort;
  logic [5:0] cnt;
  logic       busy, sched_sel, last, done, state_dbg;
  logic [7:0] blk_cnt;

  logic       b_start, b_cnt_en, b_abort;
  logic [3:0] b_cnt;
  logic       b_busy, b_sched_sel, b_last, b_done, b_state_dbg;
  logic [1:0] b_blk_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_blk;

  sha_round_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cnt_en(cnt_en), .abort(abort),
    .cnt(cnt), .busy(busy), .sched_sel(sched_sel), .last(last), .done(done),
    .blk_cnt(blk_cnt), .state_dbg(state_dbg)
  );

  sha_round_seq #(.CNT_W(4), .ROUNDS(16), .SCHED_WORDS(16), .BLK_W(2)) dut_w (
    .clk(clk), .reset_n(reset_n), .start(b_start), .cnt_en(b_cnt_en), .abort(b_abort),
    .cnt(b_cnt), .busy(b_busy), .sched_sel(b_sched_sel), .last(b_last), .done(b_done),
    .blk_cnt(b_blk_cnt), .state_dbg(b_state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    cnt_en = 1'b1;
    repeat (n) tick();
  endtask

  task automatic start_block();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_done_blk();
    check("done_pulse", done, 1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
    end else begin
      exp_blk = exp_q.pop_front();
      check("blk_cnt_at_done", blk_cnt, exp_blk);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 0; cnt_en = 0; abort = 0;
    b_start = 0; b_cnt_en = 0; b_abort = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    check("rst_cnt", cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_sched", sched_sel, 0);
    check("rst_last", last, 0);
    check("rst_done", done, 0);
    check("rst_blk", blk_cnt, 0);
    check("rst_state", state_dbg, 0);

    // reset mid-run, asserted between clock edges
    start_block();
    check("start_busy", busy, 1);
    check("start_cnt", cnt, 0);
    advance(10);
    cnt_en = 1'b0;
    check("pre_reset_cnt", cnt, 10);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_cnt", cnt, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_blk", blk_cnt, 0);
    #2 reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_cnt", cnt, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);

    // single block; cnt_en during the start cycle is ignored in IDLE
    cnt_en = 1'b1;
    start_block();
    for (int t = 0; t < 64; t++) begin
      check("blk1_cnt", cnt, t);
      check("blk1_busy", busy, 1);
      check("blk1_sched", sched_sel, (t < 16) ? 1 : 0);
      check("blk1_last", last, (t == 63) ? 1 : 0);
      check("blk1_done", done, 0);
      tick();
    end
    exp_q.push_back(8'd1);
    expect_done_blk();
    check("blk1_end_busy", busy, 0);
    check("blk1_end_cnt", cnt, 0);
    cnt_en = 1'b0;
    tick();
    check("blk1_done_one_cycle", done, 0);

    // stall at cnt=15 and at cnt=63
    start_block();
    advance(15);
    cnt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall15_cnt", cnt, 15);
      check("stall15_sched", sched_sel, 1);
    end
    advance(1);
    check("unstall_cnt", cnt, 16);
    check("unstall_sched", sched_sel, 0);
    advance(47);
    cnt_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall63_cnt", cnt, 63);
      check("stall63_last", last, 1);
      check("stall63_done", done, 0);
      check("stall63_busy", busy, 1);
    end
    exp_q.push_back(8'd2);
    advance(1);
    expect_done_blk();
    cnt_en = 1'b0;

    // back-to-back, with an ignored mid-block start
    start_block();
    advance(30);
    check("b2b_cnt30", cnt, 30);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignored_start_cnt", cnt, 31);
    advance(32);
    check("b2b_last", last, 1);
    start = 1'b1;
    exp_q.push_back(8'd3);
    tick();
    start = 1'b0;
    expect_done_blk();
    check("b2b_busy", busy, 1);
    check("b2b_cnt", cnt, 0);
    check("b2b_sched", sched_sel, 1);
    advance(63);
    check("b2b_done_low", done, 0);
    check("b2b_cnt63", cnt, 63);
    exp_q.push_back(8'd4);
    advance(1);
    expect_done_blk();
    check("b2b2_busy", busy, 0);
    cnt_en = 1'b0;

    // abort at cnt=40
    start_block();
    advance(40);
    check("abort40_cnt_pre", cnt, 40);
    abort = 1'b1;
    cnt_en = 1'b0;
    tick();
    abort = 1'b0;
    check("abort40_busy", busy, 0);
    check("abort40_cnt", cnt, 0);
    check("abort40_done", done, 0);
    check("abort40_blk", blk_cnt, 4);

    // abort together with the final advance
    start_block();
    advance(63);
    check("abort63_last", last, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cnt_en = 1'b0;
    check("abort63_done", done, 0);
    check("abort63_blk", blk_cnt, 4);
    check("abort63_busy", busy, 0);
    tick();
    check("abort63_done_later", done, 0);

    // abort beats start in IDLE
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_idle_busy", busy, 0);
    check("abort_idle_cnt", cnt, 0);
    tick();
    check("abort_idle_stay", busy, 0);

    // narrow instance: 16 rounds, full schedule, 2-bit block counter
    check("w_rst_blk", b_blk_cnt, 0);
    for (int k = 1; k <= 5; k++) begin
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_cnt_en = 1'b1;
      for (int t = 0; t < 16; t++) begin
        check("w_cnt", b_cnt, t);
        check("w_sched", b_sched_sel, 1);
        check("w_last", b_last, (t == 15) ? 1 : 0);
        tick();
      end
      b_cnt_en = 1'b0;
      check("w_done", b_done, 1);
      check("w_wrap_cnt", b_cnt, 0);
      check("w_busy", b_busy, 0);
      check("w_blk", b_blk_cnt, k % 4);
    end
    check("w_blk_final", b_blk_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
